// File: rtl/mctp_axi_pkg.sv
// Shared constants and types for the MCTP-over-PCIe VDM AXI write master.
// Packet-type codes, header field positions, AXI encodings and FSM states.
package mctp_axi_pkg;

  localparam logic [1:0] PKT_M  = 2'b00;
  localparam logic [1:0] PKT_L  = 2'b01;
  localparam logic [1:0] PKT_S  = 2'b10;
  localparam logic [1:0] PKT_SG = 2'b11;

  localparam int HDR_W       = 128;
  localparam int HDR_TYPE_HI = 127;
  localparam int HDR_TYPE_LO = 126;
  localparam int HDR_SEQ_HI  = 125;
  localparam int HDR_SEQ_LO  = 124;
  localparam int HDR_TAG_HI  = 123;
  localparam int HDR_TAG_LO  = 120;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2
  } state_t;

endpackage

// File: rtl/mctp_seq_checker.sv
// MCTP SOM/MID/EOM sequence checker: tracks the open message tag and the
// expected packet sequence number, pulsing seq_err for one cycle on a violation.
module mctp_seq_checker
  import mctp_axi_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       accept,
  input  logic [7:0] hdr_top,
  output logic       seq_err
);

  logic [1:0] pkt_type;
  logic [1:0] pkt_seq;
  logic [3:0] pkt_tag;

  logic       open_q, open_d;
  logic [3:0] tag_q, tag_d;
  logic [1:0] exp_q, exp_d;
  logic       violation;

  assign pkt_type = hdr_top[7:6];
  assign pkt_seq  = hdr_top[5:4];
  assign pkt_tag  = hdr_top[3:0];

  // Middle/last packets resynchronise the expected seq to the received one,
  // so a single dropped packet raises one error rather than a cascade.
  always_comb begin
    open_d    = open_q;
    tag_d     = tag_q;
    exp_d     = exp_q;
    violation = 1'b0;
    case (pkt_type)
      PKT_S, PKT_SG: begin
        violation = open_q;
        open_d    = (pkt_type == PKT_S);
        tag_d     = pkt_tag;
        exp_d     = pkt_seq + 2'd1;
      end
      PKT_M: begin
        violation = !open_q || (pkt_tag != tag_q) || (pkt_seq != exp_q);
        if (open_q) exp_d = pkt_seq + 2'd1;
      end
      default: begin
        violation = !open_q || (pkt_tag != tag_q) || (pkt_seq != exp_q);
        open_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      open_q  <= 1'b0;
      tag_q   <= 4'd0;
      exp_q   <= 2'd0;
      seq_err <= 1'b0;
    end else begin
      seq_err <= accept & violation;
      if (accept) begin
        open_q <= open_d;
        tag_q  <= tag_d;
        exp_q  <= exp_d;
      end
    end
  end

endmodule

// File: rtl/axi_mctp_write_master.sv
// AXI4 INCR write master for MCTP VDM packets: header rides in the low 128 bits
// of beat 0, multiple bursts may be outstanding, BRESP errors are counted.
module axi_mctp_write_master
  import mctp_axi_pkg::*;
#(
  parameter int DATA_W    = 256,
  parameter int ID_W      = 7,
  parameter int AWID_VAL  = 0,
  parameter int MAX_OUTST = 4,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic [63:0]          i_cmd_addr,
  input  logic [7:0]           i_cmd_len,
  input  logic [127:0]         i_cmd_header,
  input  logic                 i_pl_valid,
  output logic                 o_pl_ready,
  input  logic [DATA_W-1:0]    i_pl_data,
  output logic [ID_W-1:0]      O_AWID,
  output logic [63:0]          O_AWADDR,
  output logic [7:0]           O_AWLEN,
  output logic [2:0]           O_AWSIZE,
  output logic [1:0]           O_AWBURST,
  output logic                 O_AWLOCK,
  output logic [3:0]           O_AWCACHE,
  output logic [2:0]           O_AWPROT,
  output logic [63:0]          O_AWUSER,
  output logic                 O_AWVALID,
  input  logic                 I_AWREADY,
  output logic [DATA_W-1:0]    O_WDATA,
  output logic [DATA_W/8-1:0]  O_WSTRB,
  output logic                 O_WLAST,
  output logic [15:0]          O_WUSER,
  output logic                 O_WVALID,
  input  logic                 I_WREADY,
  input  logic [ID_W-1:0]      I_BID,
  input  logic [1:0]           I_BRESP,
  input  logic                 I_BVALID,
  output logic                 O_BREADY,
  output logic                 o_busy,
  output logic [3:0]           o_outstanding,
  output logic [ERR_CNT_W-1:0] o_err_cnt,
  output logic [1:0]           o_last_bresp,
  output logic                 o_seq_err
);

  localparam logic [2:0] AXSIZE = 3'($clog2(DATA_W / 8));

  state_t                 state_q, state_d;
  logic [63:0]            addr_q;
  logic [7:0]             len_q;
  logic [HDR_W-1:0]       hdr_q;
  logic [7:0]             beat_q;
  logic [3:0]             outst_q;
  logic [ERR_CNT_W-1:0]   err_q;
  logic [1:0]             bresp_q;
  logic                   bready_q;

  logic cmd_hs, aw_hs, w_hs, b_hs, b_counted, last_beat;
  logic bid_unused;

  assign bid_unused = ^I_BID;

  assign cmd_hs    = i_cmd_valid & o_cmd_ready;
  assign aw_hs     = O_AWVALID & I_AWREADY;
  assign w_hs      = O_WVALID & I_WREADY;
  assign b_hs      = I_BVALID & O_BREADY;
  assign b_counted = b_hs & (outst_q != 4'd0);
  assign last_beat = (beat_q == len_q);

  assign O_AWID    = ID_W'(AWID_VAL);
  assign O_AWADDR  = addr_q;
  assign O_AWLEN   = len_q;
  assign O_AWSIZE  = AXSIZE;
  assign O_AWBURST = AXI_BURST_INCR;
  assign O_AWLOCK  = 1'b0;
  assign O_AWCACHE = 4'd0;
  assign O_AWPROT  = 3'd0;
  assign O_AWUSER  = 64'd0;
  assign O_WSTRB   = '1;
  assign O_WUSER   = 16'd0;
  assign O_BREADY  = bready_q;

  assign o_busy        = (state_q != ST_IDLE) || (outst_q != 4'd0);
  assign o_outstanding = outst_q;
  assign o_err_cnt     = err_q;
  assign o_last_bresp  = bresp_q;

  // Handshake outputs are gated by reset so nothing transfers in the reset cycle.
  always_comb begin
    state_d     = state_q;
    o_cmd_ready = 1'b0;
    O_AWVALID   = 1'b0;
    O_WVALID    = 1'b0;
    O_WLAST     = 1'b0;
    o_pl_ready  = 1'b0;
    O_WDATA     = i_pl_data;
    if (beat_q == 8'd0) O_WDATA = {i_pl_data[DATA_W-1:HDR_W], hdr_q};
    case (state_q)
      ST_IDLE: begin
        o_cmd_ready = !i_reset && (outst_q < 4'(MAX_OUTST));
        if (cmd_hs) state_d = ST_AW;
      end
      ST_AW: begin
        O_AWVALID = !i_reset;
        if (I_AWREADY) state_d = ST_W;
      end
      ST_W: begin
        O_WVALID   = !i_reset && i_pl_valid;
        o_pl_ready = !i_reset && I_WREADY;
        O_WLAST    = last_beat;
        if (w_hs && last_beat) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= 64'd0;
      len_q    <= 8'd0;
      hdr_q    <= '0;
      beat_q   <= 8'd0;
      outst_q  <= 4'd0;
      err_q    <= '0;
      bresp_q  <= 2'd0;
      bready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bready_q <= 1'b1;
      if (cmd_hs) begin
        addr_q <= i_cmd_addr;
        len_q  <= i_cmd_len;
        hdr_q  <= i_cmd_header;
        beat_q <= 8'd0;
      end else if (w_hs) begin
        beat_q <= last_beat ? 8'd0 : beat_q + 8'd1;
      end
      if (aw_hs && !b_counted) outst_q <= outst_q + 4'd1;
      else if (!aw_hs && b_counted) outst_q <= outst_q - 4'd1;
      if (b_hs) bresp_q <= I_BRESP;
      if (b_counted && (I_BRESP != AXI_RESP_OKAY) && (err_q != {ERR_CNT_W{1'b1}}))
        err_q <= err_q + 1'b1;
    end
  end

  mctp_seq_checker u_seq_checker (
    .clk     (i_clk),
    .reset   (i_reset),
    .accept  (cmd_hs),
    .hdr_top (i_cmd_header[HDR_TYPE_HI:HDR_TAG_LO]),
    .seq_err (o_seq_err)
  );

endmodule
